// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO: operation encoding and
// the width helper used to size the occupancy counter and storage address.
package lifo_pkg;

   typedef enum logic [2:0] {
      OP_NONE    = 3'd0,
      OP_PUSH    = 3'd1,
      OP_POP     = 3'd2,
      OP_REPLACE = 3'd3,
      OP_BYPASS  = 3'd4
   } lifo_op_e;

   // Smallest bit count able to represent the value 'depth'.
   function automatic int unsigned cnt_width(input int unsigned depth);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) <= depth) w = w + 1;
      return w;
   endfunction

   // Refused pushes (full) and refused pops (empty) decode to OP_NONE.
   function automatic lifo_op_e decode_op(input logic push, input logic pop,
                                          input logic empty, input logic full);
      lifo_op_e op;
      case ({push, pop})
         2'b10:   op = full  ? OP_NONE   : OP_PUSH;
         2'b01:   op = empty ? OP_NONE   : OP_POP;
         2'b11:   op = empty ? OP_BYPASS : OP_REPLACE;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/lifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are not reset.
module lifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             Clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage write port
   always_ff @(posedge Clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Addresses beyond DEPTH-1 exist only for non-power-of-two depths
   assign rdata = (int'(raddr) < DEPTH) ? mem_r[raddr] : {WIDTH{1'b0}};

endmodule

// File: rtl/param_lifo.sv
// Parametrised LIFO stack controller: occupancy count, status flags, sticky
// error flags and the registered pop output. Storage lives in lifo_mem.
module param_lifo
   import lifo_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int DEPTH    = 16,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 2,
   localparam int CNT_W    = cnt_width(DEPTH)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] top,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = cnt_width(DEPTH - 1);

   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] data_out_r;
   logic             out_valid_r;
   logic             overflow_r;
   logic             underflow_r;
   logic             empty_s;
   logic             full_s;
   logic             ovf_s;
   logic             unf_s;
   lifo_op_e         op_s;
   logic             we_s;
   logic [AW-1:0]    waddr_s;
   logic [AW-1:0]    top_idx_s;
   logic [WIDTH-1:0] rdata_s;

   assign empty_s   = (count_r == {CNT_W{1'b0}});
   assign full_s    = (count_r == CNT_W'(DEPTH));
   // Low bits of count-1 still address DEPTH-1 when DEPTH is a power of two
   assign top_idx_s = count_r[AW-1:0] - AW'(1'b1);
   assign op_s      = decode_op(push, pop, empty_s, full_s);
   assign ovf_s     = push & ~pop & full_s;
   assign unf_s     = pop & ~push & empty_s;

   // Storage write control: append on push, overwrite top on replace
   always_comb begin
      we_s    = 1'b0;
      waddr_s = count_r[AW-1:0];
      if (clear) begin
         we_s = 1'b0;
      end else if (op_s == OP_PUSH) begin
         we_s    = 1'b1;
         waddr_s = count_r[AW-1:0];
      end else if (op_s == OP_REPLACE) begin
         we_s    = 1'b1;
         waddr_s = top_idx_s;
      end else begin
         we_s = 1'b0;
      end
   end

   lifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .Clk   (Clk),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (data_in),
      .raddr (top_idx_s),
      .rdata (rdata_s)
   );

   // Occupancy, pop output register and sticky error flags
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         count_r     <= {CNT_W{1'b0}};
         data_out_r  <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (clear) begin
         count_r     <= {CNT_W{1'b0}};
         out_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         case (op_s)
            OP_PUSH: begin
               count_r     <= count_r + CNT_W'(1'b1);
               out_valid_r <= 1'b0;
            end
            OP_POP: begin
               count_r     <= count_r - CNT_W'(1'b1);
               data_out_r  <= rdata_s;
               out_valid_r <= 1'b1;
            end
            OP_REPLACE: begin
               data_out_r  <= rdata_s;
               out_valid_r <= 1'b1;
            end
            OP_BYPASS: begin
               data_out_r  <= data_in;
               out_valid_r <= 1'b1;
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
         overflow_r  <= overflow_r | ovf_s;
         underflow_r <= underflow_r | unf_s;
      end
   end

   assign count        = count_r;
   assign data_out     = data_out_r;
   assign out_valid    = out_valid_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;
   assign empty        = empty_s;
   assign full         = full_s;
   assign almost_empty = (int'(count_r) <= AE_LEVEL);
   assign almost_full  = (int'(count_r) >= AF_LEVEL);
   assign top          = empty_s ? {WIDTH{1'b0}} : rdata_s;

endmodule

// File: tb/tb_param_lifo.sv
// Directed self-checking bench for param_lifo (WIDTH=8, DEPTH=16, AF=14, AE=2):
// a stack model predicts state, popped words go through a scoreboard queue.
module tb_param_lifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic             Clk;
   logic             Rst;
   logic             clear;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic [WIDTH-1:0] top;
   logic [4:0]       count;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic             overflow;
   logic             underflow;

   param_lifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .clear        (clear),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .out_valid    (out_valid),
      .top          (top),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int unsigned      vectors;
   int unsigned      miscompares;
   logic [WIDTH-1:0] stk[$];
   logic [WIDTH-1:0] exp_q[$];
   logic             m_ovf;
   logic             m_unf;
   logic             m_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int sz;
      logic [WIDTH-1:0] exp_top;
      sz = stk.size();
      exp_top = (sz > 0) ? stk[sz-1] : 8'h00;
      check({tag, ".count"},        32'(count),        32'(sz));
      check({tag, ".out_valid"},    32'(out_valid),    32'(m_valid));
      check({tag, ".top"},          32'(top),          32'(exp_top));
      check({tag, ".empty"},        32'(empty),        32'(sz == 0));
      check({tag, ".full"},         32'(full),         32'(sz == DEPTH));
      check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
      check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
      check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
      check({tag, ".underflow"},    32'(underflow),    32'(m_unf));
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check({tag, ".unexpected_pop"}, 32'(data_out), 32'hFFFF_FFFF);
         end else begin
            check({tag, ".data_out"}, 32'(data_out), 32'(exp_q.pop_front()));
         end
      end
   endtask

   // One clock with the given strobes; the model is updated as stimulus is driven
   task automatic cycle(input string tag, input logic p, input logic q, input logic c,
                        input logic [WIDTH-1:0] d);
      int sz;
      push = p; pop = q; clear = c; data_in = d;
      sz = stk.size();
      m_valid = 1'b0;
      if (c) begin
         stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (p && q) begin
         m_valid = 1'b1;
         if (sz > 0) begin
            exp_q.push_back(stk[sz-1]);
            stk[sz-1] = d;
         end else begin
            exp_q.push_back(d);
         end
      end else if (p) begin
         if (sz < DEPTH) stk.push_back(d);
         else m_ovf = 1'b1;
      end else if (q) begin
         if (sz > 0) begin
            exp_q.push_back(stk.pop_back());
            m_valid = 1'b1;
         end else begin
            m_unf = 1'b1;
         end
      end
      @(posedge Clk);
      #1;
      push = 1'b0; pop = 1'b0; clear = 1'b0;
      check_state(tag);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
      Rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;

      // 1: reset then idle
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b1;
      check_state("reset");
      check("reset.data_out", 32'(data_out), 32'h0);
      cycle("idle", 1'b0, 1'b0, 1'b0, 8'h00);

      // 2: fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
      cycle("ovf_push", 1'b1, 1'b0, 1'b0, 8'hEE);
      for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("drain_idle", 1'b0, 1'b0, 1'b0, 8'h00);

      // 3: underflow, then clear drops both sticky flags
      cycle("unf_pop", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("unf_hold", 1'b0, 1'b0, 1'b0, 8'h00);
      cycle("clear", 1'b0, 1'b0, 1'b1, 8'h00);

      // 4: replace-top, bypass, clear wins over push+pop
      cycle("push_a5", 1'b1, 1'b0, 1'b0, 8'hA5);
      cycle("replace", 1'b1, 1'b1, 1'b0, 8'h3C);
      cycle("pop_3c", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("bypass", 1'b1, 1'b1, 1'b0, 8'h77);
      cycle("clr_pp", 1'b1, 1'b1, 1'b1, 8'h99);

      // 5: almost thresholds, then replace while full
      for (int i = 0; i < 14; i++) cycle("af_fill", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      cycle("af_13", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("af_14", 1'b1, 1'b0, 1'b0, 8'hC4);
      cycle("af_15", 1'b1, 1'b0, 1'b0, 8'hC5);
      cycle("af_16", 1'b1, 1'b0, 1'b0, 8'hC6);
      cycle("full_repl", 1'b1, 1'b1, 1'b0, 8'hD6);
      while (stk.size() > 2) cycle("ae_drain", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("clear2", 1'b0, 1'b0, 1'b1, 8'h00);

      // 6: asynchronous reset mid-burst with a pop pending
      for (int i = 0; i < 7; i++) cycle("pre_rst", 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
      pop = 1'b1;
      #2 Rst = 1'b0;
      #1;
      stk.delete(); exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
      check_state("async_rst");
      check("async_rst.data_out", 32'(data_out), 32'h0);
      pop = 1'b0;
      @(posedge Clk);
      #1 Rst = 1'b1;
      cycle("post_rst", 1'b1, 1'b0, 1'b0, 8'h5A);
      cycle("post_pop", 1'b0, 1'b1, 1'b0, 8'h00);

      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
